// File: rtl/sram_pkg.sv
// Shared constants and state encoding for sram_array and its init controller.
// Optional feature macro used by the array: PARITY_EN.
package sram_pkg;
    localparam logic RDWR_WRITE = 1'b0;
    localparam logic RDWR_READ  = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;
endpackage

// File: rtl/sram_array_if.sv
// Request/response bundle between a storage client (master) and sram_array (slave).
interface sram_array_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              select;
    logic              rdwr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid;
    logic              ready;
    logic              parity_err;

    modport master (
        output select, rdwr, addr, din,
        input  dout, dout_valid, ready, parity_err
    );

    modport slave (
        input  select, rdwr, addr, din,
        output dout, dout_valid, ready, parity_err
    );
endinterface

// File: rtl/sram_init_ctrl.sv
// INIT/IDLE sequencer: walks a pointer over every word after reset, then raises ready.
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic              ready_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ready_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            if (ptr_q == LAST_ADDR) begin
                state_q <= ST_IDLE;
                ptr_q   <= '0;
                ready_q <= 1'b1;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    assign init_we_o   = (state_q == ST_INIT);
    assign init_addr_o = ptr_q;
    assign ready_o     = ready_q;
endmodule

// File: rtl/sram_array.sv
// Single-port DEPTH x WIDTH RAM with registered read, post-reset clearing sweep,
// and optional per-word even parity (macro PARITY_EN).
module sram_array
    import sram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         RST,
    sram_array_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              init_ready;

    sram_init_ctrl #(.DEPTH(DEPTH)) u_init (
        .clk_i       (CLK),
        .rst_i       (RST),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .ready_o     (init_ready)
    );

    // Only reachable out of range when DEPTH is not a power of two.
    logic addr_ok;
    logic user_wr;
    logic user_rd;
    assign addr_ok = ({1'b0, bus.addr} < DEPTH_L);
    assign user_wr = init_ready & bus.select & (bus.rdwr == RDWR_WRITE) & addr_ok;
    assign user_rd = init_ready & bus.select & (bus.rdwr == RDWR_READ);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    assign wr_en   = init_we | user_wr;
    assign wr_addr = init_we ? init_addr : bus.addr;
    assign wr_data = init_we ? '0 : bus.din;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; the post-reset sweep clears it so it can map onto plain RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= user_rd;
            if (user_rd) begin
                dout_q <= addr_ok ? mem_q[bus.addr] : '0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.ready      = init_ready;

`ifdef PARITY_EN
    logic par_q [DEPTH];
    logic parity_err_q;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            par_q[wr_addr] <= init_we ? 1'b0 : ^bus.din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            parity_err_q <= 1'b0;
        end else if (user_rd) begin
            parity_err_q <= addr_ok && ((^mem_q[bus.addr]) != par_q[bus.addr]);
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_array.sv
// Directed bench for sram_array: sweep, init-time ignore, read/write, out-of-range, reset abort.
module tb_sram_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    sram_array_if #(.WIDTH(8), .DEPTH(16)) bus16 ();
    sram_array_if #(.WIDTH(8), .DEPTH(10)) bus10 ();

    sram_array #(.WIDTH(8), .DEPTH(16)) u_dut16 (.CLK(clk), .RST(rst), .bus(bus16.slave));
    sram_array #(.WIDTH(8), .DEPTH(10)) u_dut10 (.CLK(clk), .RST(rst), .bus(bus10.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv16(input logic sel, input logic rw, input logic [3:0] a, input logic [7:0] d);
        bus16.select = sel;
        bus16.rdwr   = rw;
        bus16.addr   = a;
        bus16.din    = d;
    endtask

    task automatic drv10(input logic sel, input logic rw, input logic [3:0] a, input logic [7:0] d);
        bus10.select = sel;
        bus10.rdwr   = rw;
        bus10.addr   = a;
        bus10.din    = d;
    endtask

    initial begin
        drv16(1'b0, 1'b0, 4'd0, 8'h00);
        drv10(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();

        check("reset_ready16", bus16.ready, 0);
        check("reset_dout16", bus16.dout, 0);
        check("reset_valid16", bus16.dout_valid, 0);
        check("reset_perr16", bus16.parity_err, 0);
        check("reset_ready10", bus10.ready, 0);

        // Release; requests at edges 3..5 fall inside the sweep and must be ignored.
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("sweep_ready16_c%0d", c), bus16.ready, (c == 16));
            check($sformatf("sweep_ready10_c%0d", c), bus10.ready, (c >= 10));
            check($sformatf("sweep_valid16_c%0d", c), bus16.dout_valid, 0);
            if (c == 2) drv16(1'b1, 1'b0, 4'd3, 8'hA5);
            if (c == 3) drv16(1'b1, 1'b0, 4'd1, 8'h5A);
            if (c == 4) drv16(1'b1, 1'b1, 4'd1, 8'h00);
            if (c == 5) drv16(1'b0, 1'b0, 4'd0, 8'h00);
        end

        // Back-to-back reads of every word: all cleared, valid on consecutive cycles.
        for (int a = 0; a < 16; a++) begin
            drv16(1'b1, 1'b1, 4'(a), 8'h00);
            tick();
            check($sformatf("clear_dout_a%0d", a), bus16.dout, 0);
            check($sformatf("clear_valid_a%0d", a), bus16.dout_valid, 1);
            check($sformatf("clear_perr_a%0d", a), bus16.parity_err, 0);
        end
        drv16(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        check("idle_after_sweep_valid", bus16.dout_valid, 0);

        drv16(1'b1, 1'b0, 4'd5, 8'h3C);
        tick();
        check("wr5_valid", bus16.dout_valid, 0);
        drv16(1'b1, 1'b1, 4'd5, 8'h00);
        tick();
        check("rd5_dout", bus16.dout, 8'h3C);
        check("rd5_valid", bus16.dout_valid, 1);
        drv16(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        check("hold5_valid", bus16.dout_valid, 0);
        check("hold5_dout", bus16.dout, 8'h3C);

        drv16(1'b1, 1'b0, 4'd6, 8'h01);
        tick();
        drv16(1'b1, 1'b1, 4'd6, 8'h00);
        tick();
        check("rd6_dout", bus16.dout, 8'h01);
        check("rd6_perr", bus16.parity_err, 0);
        drv16(1'b1, 1'b0, 4'd7, 8'h03);
        tick();
        drv16(1'b1, 1'b1, 4'd7, 8'h00);
        tick();
        check("rd7_dout", bus16.dout, 8'h03);
        check("rd7_perr", bus16.parity_err, 0);
        drv16(1'b1, 1'b0, 4'd0, 8'h77);
        tick();
        drv16(1'b0, 1'b0, 4'd0, 8'h00);

        // DEPTH=10: address 12 does not exist; its write is dropped and its read returns zero.
        drv10(1'b1, 1'b0, 4'd9, 8'h42);
        tick();
        drv10(1'b1, 1'b0, 4'd12, 8'hFF);
        tick();
        drv10(1'b1, 1'b1, 4'd9, 8'h00);
        tick();
        check("d10_rd9_dout", bus10.dout, 8'h42);
        check("d10_rd9_valid", bus10.dout_valid, 1);
        drv10(1'b1, 1'b1, 4'd12, 8'h00);
        tick();
        check("d10_rd12_dout", bus10.dout, 0);
        check("d10_rd12_valid", bus10.dout_valid, 1);
        check("d10_rd12_perr", bus10.parity_err, 0);
        drv10(1'b1, 1'b1, 4'd4, 8'h00);
        tick();
        check("d10_rd4_dout", bus10.dout, 0);
        drv10(1'b1, 1'b1, 4'd9, 8'h00);
        tick();
        check("d10_rd9_again", bus10.dout, 8'h42);
        drv10(1'b0, 1'b0, 4'd0, 8'h00);

        // Asynchronous reset, then a second reset part-way through the sweep.
        rst = 1'b1;
        #1;
        check("async_rst_dout", bus16.dout, 0);
        check("async_rst_valid", bus16.dout_valid, 0);
        check("async_rst_ready", bus16.ready, 0);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("part_sweep_ready_c%0d", c), bus16.ready, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("resweep_ready_c%0d", c), bus16.ready, (c == 16));
        end

        drv16(1'b1, 1'b1, 4'd0, 8'h00);
        tick();
        check("resweep_rd0_dout", bus16.dout, 0);
        check("resweep_rd0_valid", bus16.dout_valid, 1);
        drv16(1'b1, 1'b1, 4'd5, 8'h00);
        tick();
        check("resweep_rd5_dout", bus16.dout, 0);
        drv16(1'b0, 1'b0, 4'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sram_array.md
# sram_array

Parametrised synchronous single-port RAM, the multi-bit, multi-word successor to the single-cell binary RAM. It stores DEPTH words of WIDTH bits, and selects read or write with the same select/rdwr convention as the cell. Reads are registered and flagged valid. After every reset a hardware sweep clears the array before accepting requests. It sits behind any block needing small local storage: register files, scratch buffers, lookup tables.

## Interface
- WIDTH, default 8: data word width in bits (≥1).
- DEPTH, default 16: number of words (≥2; need not be a power of two).
- ADDR_W, default $clog2(DEPTH): address width, derived; not overridden.
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- select  input  1  request strobe; sampled each rising edge.
- rdwr  input  1  0 = write, 1 = read; qualified by select.
- addr  input  ADDR_W  word address.
- din  input  WIDTH  write data.
- dout  output  WIDTH  read data, registered.
- dout_valid  output  1  one-cycle pulse: dout updated by a read this cycle.
- ready  output  1  high when requests are accepted (init sweep done).
- parity_err  output  1  parity mismatch on the read presented with dout_valid (see Configuration).

## Operation
- States: INIT, IDLE. RST asserted forces INIT, init pointer = 0.
- INIT: each cycle writes all-zero (and parity bit 0) to word[pointer], then pointer+1. After word DEPTH-1 is written, the next state is IDLE. All select requests during INIT are ignored; no write occurs and no dout_valid is produced.
- IDLE: select=1, rdwr=0 writes din to word[addr]. select=1, rdwr=1 loads dout ← word[addr] and pulses dout_valid. select=0 does nothing.
- addr ≥ DEPTH, which can only occur when DEPTH is not a power of two: a write is dropped. A read returns all-zero with dout_valid=1 and parity_err=0.
- A write followed by a read of the same address on the next cycle returns the new data.
- dout holds its last value between reads. It is not cleared by the sweep.
- RST asserted mid-sweep or mid-operation aborts immediately, with outputs at reset values. On release, the sweep restarts from word 0.

## Timing
- Reset values: dout=0, dout_valid=0, ready=0, parity_err=0, state=INIT, pointer=0.
- The sweep takes exactly DEPTH cycles after RST deasserts. ready rises at the edge that enters IDLE, DEPTH edges after release.
- Read latency is 1 cycle. A request sampled at edge n gives dout, dout_valid and parity_err valid after edge n. dout_valid drops at edge n+1 unless another read is sampled.
- Write latency is 1 cycle. Data is visible to a read sampled at the next edge.
- One operation per cycle. Back-to-back reads produce dout_valid high on consecutive cycles.

## Configuration
- PARITY_EN defined:
  - Each word stores an extra even-parity bit, ^din, on write.
  - On read, parity_err = (^word_data != stored_bit), registered with dout.
  - The sweep stores parity 0 alongside the zero data.
- PARITY_EN undefined:
  - No parity storage is built.
  - The parity_err port remains and is tied to 0.

## Structure
- Shared package sram_pkg:
  - constants RDWR_WRITE=1'b0, RDWR_READ=1'b1;
  - state encoding ST_INIT, ST_IDLE.
- Sub-module sram_init_ctrl:
  - the INIT/IDLE FSM and init pointer, parametrised by DEPTH;
  - outputs init_we, init_addr and ready.
- The top module muxes init_we/init_addr against the user port and holds the array and output registers.

## Test plan
- Sweep: DEPTH=16; release RST at t0. ready=0 for 16 cycles, then 1. Reading every address afterwards gives dout=0, dout_valid=1 and parity_err=0 on each.
- Ignore during init: select=1, rdwr=0, addr=3, din=8'hA5 issued 2 cycles after release. After ready, a read of addr 3 gives 8'h00.
- Write/read back-to-back: write 8'h3C to addr 5, then read addr 5 the next cycle. dout=8'h3C with dout_valid one cycle after the read edge. A following idle cycle gives dout_valid=0 with dout held at 8'h3C.
- Non-power-of-two depth, DEPTH=10: write 8'hFF to addr 12, then read addr 12. Result is dout=0 with dout_valid=1; a read of addr 9 is unaffected.
- Reset mid-sweep: assert RST at sweep cycle 7 of 16, release. ready rises 16 cycles after the second release. A read of addr 0 gives 0.
- PARITY_EN: writes of 8'h01 and 8'h03 read back with parity_err=0. Without the macro, parity_err is constantly 0.
